// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_evt_pkg
// Purpose  : Shared state encoding and board-clock timing defaults for the
//            button gesture decoder.
// Revision : 1.0  initial release
// ============================================================================
package btn_evt_pkg;

    typedef enum logic [2:0] {
        LOCKOUT,
        IDLE,
        DOWN1,
        LONG,
        GAP,
        DOWN2
    } btn_evt_state_t;

    // 0.5 s and 0.25 s at the 50 MHz board clock
    localparam int c_long_cycles_dflt = 25_000_000;
    localparam int c_gap_cycles_dflt  = 12_500_000;

endpackage
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : edge_detector
// Purpose  : Registers a synchronised level and flags its rising/falling edges.
// Revision : 1.0  initial release
// ============================================================================
module edge_detector #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic level_q,
    output logic rise,
    output logic fall
);

    logic r_level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_q <= RESET_LEVEL;
        end else begin
            r_level_q <= level;
        end
    end

    assign level_q = r_level_q;
    assign rise    = level & ~r_level_q;
    assign fall    = ~level & r_level_q;

endmodule
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Turns a debounced button level into single-cycle press, release,
//            click, double-click and long-press events using one timer.
// Revision : 1.0  initial release
// ============================================================================
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYCLES = c_long_cycles_dflt,
    parameter int GAP_CYCLES  = c_gap_cycles_dflt
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press,
    output logic release_evt,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic held
);

    localparam int c_max_cycles = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int CTR_W        = $clog2(c_max_cycles + 1);

    localparam logic [CTR_W-1:0] c_long_last = CTR_W'(LONG_CYCLES - 1);
    localparam logic [CTR_W-1:0] c_gap_last  = CTR_W'(GAP_CYCLES - 1);
    localparam logic [CTR_W-1:0] c_ctr_max   = {CTR_W{1'b1}};

    generate
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("button_event_decoder: LONG_CYCLES must be >= 2");
        end
        if (GAP_CYCLES < 2) begin : g_bad_gap
            $error("button_event_decoder: GAP_CYCLES must be >= 2");
        end
    endgenerate

    btn_evt_state_t   r_state;
    btn_evt_state_t   w_next_state;
    logic [CTR_W-1:0] r_ctr;

    logic w_rise;
    logic w_fall;
    logic w_press;
    logic w_release;
    logic w_click;
    logic w_double;
    logic w_long;

    // Powers up assuming the button is held, so a hold through reset stays silent
    edge_detector #(
        .RESET_LEVEL (1'b1)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .level   (level),
        .level_q (held),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    always_comb begin
        w_next_state = r_state;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_click      = 1'b0;
        w_double     = 1'b0;
        w_long       = 1'b0;
        case (r_state)
            LOCKOUT: begin
                if (!level) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_next_state = DOWN1;
                    w_press      = 1'b1;
                end
            end
            DOWN1: begin
                if (w_fall) begin
                    w_next_state = GAP;
                    w_release    = 1'b1;
                end else if (r_ctr == c_long_last) begin
                    w_next_state = LONG;
                    w_long       = 1'b1;
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_next_state = IDLE;
                    w_release    = 1'b1;
                end
            end
            GAP: begin
                // A second press on the timeout cycle still counts as a double click
                if (w_rise) begin
                    w_next_state = DOWN2;
                    w_press      = 1'b1;
                    w_double     = 1'b1;
                end else if (r_ctr == c_gap_last) begin
                    w_next_state = IDLE;
                    w_click      = 1'b1;
                end
            end
            DOWN2: begin
                if (w_fall) begin
                    w_next_state = IDLE;
                    w_release    = 1'b1;
                end
            end
            default: begin
                w_next_state = LOCKOUT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LOCKOUT;
            r_ctr        <= '0;
            press        <= 1'b0;
            release_evt  <= 1'b0;
            click        <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            press        <= w_press;
            release_evt  <= w_release;
            click        <= w_click;
            double_click <= w_double;
            long_press   <= w_long;
            // Time is measured from state entry and saturates instead of wrapping
            if (w_next_state != r_state) begin
                r_ctr <= '0;
            end else if (r_ctr != c_ctr_max) begin
                r_ctr <= r_ctr + CTR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_decoder
// Purpose  : Randomised and directed scoreboard bench for button_event_decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int LONG_CYCLES = 8;
    localparam int GAP_CYCLES  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic level = 1'b1;
    logic press, release_evt, click, double_click, long_press, held;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // {held, press, release_evt, click, double_click, long_press}
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_CYCLES (LONG_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .level        (level),
        .press        (press),
        .release_evt  (release_evt),
        .click        (click),
        .double_click (double_click),
        .long_press   (long_press),
        .held         (held)
    );

    // Reference model: gestures described by timestamps of the last press / short release
    localparam int H_NONE   = 0;
    localparam int H_FIRST  = 1;
    localparam int H_LONGED = 2;
    localparam int H_SECOND = 3;

    bit m_armed    = 1'b0;
    bit m_prev     = 1'b1;
    bit m_gap_open = 1'b0;
    int m_hold     = H_NONE;
    int m_t_press  = 0;
    int m_t_rel    = 0;
    int m_n        = 0;

    always @(posedge clk) begin
        logic [5:0] e;
        bit rise_s, fall_s;
        m_n++;
        e = '0;
        if (rst) begin
            m_armed    = 1'b0;
            m_prev     = 1'b1;
            m_gap_open = 1'b0;
            m_hold     = H_NONE;
        end else begin
            rise_s = level && !m_prev;
            fall_s = !level && m_prev;
            if (!m_armed) begin
                if (!level) m_armed = 1'b1;
            end else if (m_hold != H_NONE) begin
                if (fall_s) begin
                    e[3] = 1'b1;
                    if (m_hold == H_FIRST) begin
                        m_gap_open = 1'b1;
                        m_t_rel    = m_n;
                    end
                    m_hold = H_NONE;
                end else if (m_hold == H_FIRST && (m_n - m_t_press) == LONG_CYCLES) begin
                    e[0]   = 1'b1;
                    m_hold = H_LONGED;
                end
            end else if (m_gap_open) begin
                if (rise_s) begin
                    e[4]       = 1'b1;
                    e[1]       = 1'b1;
                    m_hold     = H_SECOND;
                    m_gap_open = 1'b0;
                end else if ((m_n - m_t_rel) == GAP_CYCLES) begin
                    e[2]       = 1'b1;
                    m_gap_open = 1'b0;
                end
            end else if (rise_s) begin
                e[4]      = 1'b1;
                m_hold    = H_FIRST;
                m_t_press = m_n;
            end
            m_prev = level;
        end
        e[5] = m_prev;
        exp_q.push_back(e);
    end

    // Monitor: compares every presented output vector against the scoreboard
    always @(negedge clk) begin
        logic [5:0] got, want;
        cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {held, press, release_evt, click, double_click, long_press};
            n_checks++;
            if (got !== want) begin
                n_fails++;
                $display("FAIL outputs cyc=%0d {held,press,rel,click,dbl,long} got=%b want=%b",
                         cyc, got, want);
            end
        end
    end

    task automatic drive(input bit l, input int n);
        repeat (n) begin
            @(negedge clk);
            level = l;
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit l;
        // 1: held through reset, no events until released
        rst   = 1'b1;
        level = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({press, release_evt, click, double_click, long_press} !== 5'b0 || held !== 1'b1) begin
            n_fails++;
            $display("FAIL reset state: press=%b rel=%b click=%b dbl=%b long=%b held=%b",
                     press, release_evt, click, double_click, long_press, held);
        end
        rst = 1'b0;
        drive(1'b1, 5);
        drive(1'b0, 6);
        // 2: short click, with a bounded wait for the click pulse
        drive(1'b1, 3);
        fork
            drive(1'b0, 10);
            begin
                int k;
                k = 0;
                while (click !== 1'b1 && k < 12) begin
                    @(negedge clk);
                    k++;
                end
                n_checks++;
                if (click !== 1'b1) begin
                    n_fails++;
                    $display("FAIL timeout: click not seen within %0d cycles of release", k);
                end
            end
        join
        // 3: double click
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 2);
        drive(1'b0, 10);
        // 4: long press
        drive(1'b1, 20);
        drive(1'b0, 10);
        // 5: second press lands on the gap timeout cycle, then just past it
        drive(1'b1, 2);
        drive(1'b0, 4);
        drive(1'b1, 2);
        drive(1'b0, 10);
        drive(1'b1, 2);
        drive(1'b0, 5);
        drive(1'b1, 2);
        drive(1'b0, 10);
        // 6: reset during first hold
        drive(1'b1, 3);
        pulse_rst();
        drive(1'b1, 12);
        drive(1'b0, 3);
        drive(1'b1, 2);
        drive(1'b0, 10);
        // random segments with occasional reset
        l = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 19) == 0) pulse_rst();
            drive(l, $urandom_range(1, 13));
            l = ~l;
        end
        drive(1'b0, 15);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
